lsu: RTL and testbench

Load/store unit between the core datapath and the data-memory bus. It takes one load or store request per transaction and performs byte/halfword lane alignment, write strobes and load sign/zero extension. It detects misalignment and illegal funct3 codes, and runs a valid/ready bus handshake with a response-timeout watchdog. Its stall output holds the core's PC while an access is outstanding.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_if.sv | 31 +++
 rtl/lsu_align.sv | 80 ++++++++
 rtl/lsu.sv | 197 +++++++++++++++++++
 tb/tb_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared constants, FSM state type and funct3 legality helper
//                for the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // RISC-V funct3 encodings for load/store widths
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Stores only have signed-width codes; loads also allow the unsigned variants
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ============================================================================
//  Module      : lsu_if
//  Description : Data-memory bus between the load/store unit (master) and
//                the memory system (slave). Valid/ready request channel and
//                a read-data-valid return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational lane logic for the load/store unit:
//                store data replication and byte strobes, load extraction
//                with sign/zero extension, misalignment and funct3 checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_store_wdata,
  output logic [3:0]  o_store_wstrb,
  output logic [31:0] o_load_data,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Replicate store data across all lanes and enable only the addressed bytes
  always_comb begin
    o_store_wdata = i_wdata;
    o_store_wstrb = 4'b0000;
    case (i_funct3[1:0])
      2'b00: begin
        o_store_wdata = {4{i_wdata[7:0]}};
        o_store_wstrb = 4'b0001 << i_lane;
      end
      2'b01: begin
        o_store_wdata = {2{i_wdata[15:0]}};
        o_store_wstrb = i_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_store_wdata = i_wdata;
        o_store_wstrb = 4'b1111;
      end
    endcase
    // Loads never write any byte
    if (!i_we) begin
      o_store_wstrb = 4'b0000;
    end
  end

  // Pick the addressed byte/halfword out of the read word and extend it
  always_comb begin
    w_byte      = i_rdata[{i_lane, 3'b000} +: 8];
    w_half      = i_rdata[{i_lane[1], 4'b0000} +: 16];
    o_load_data = 32'h0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_rdata;
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = 32'h0;
    endcase
  end

  // Flag accesses that must be answered with an error and no bus traffic
  always_comb begin
    o_illegal    = !f3_legal(i_we, i_funct3);
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b01:   o_misaligned = i_lane[0];
      2'b10:   o_misaligned = (i_lane != 2'b00);
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. Accepts one core access at a time, checks
//                it, drives a valid/ready data bus, waits for read data under
//                a watchdog and returns a single-cycle response. Stall holds
//                the core PC while an access is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  lsu_if.master       mem
);

  // Expiry is detected one count early so the error lands exactly
  // TIMEOUT_CYCLES cycles after entering WAIT_R
  localparam logic [7:0] c_timeout_m1 = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_state_nxt;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;

  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;

  logic [31:0] r_rsp_rdata;
  logic [31:0] w_rsp_rdata_nxt;
  logic        r_rsp_err;
  logic        w_rsp_err_nxt;

  logic        w_sel_we;
  logic [2:0]  w_sel_funct3;
  logic [1:0]  w_sel_lane;
  logic [31:0] w_store_wdata;
  logic [3:0]  w_store_wstrb;
  logic [31:0] w_load_data;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_fault;
  logic        w_launch;

  // In IDLE the checker looks at the live request; afterwards at the capture
  assign w_sel_we     = (r_state == IDLE) ? req_we          : r_we;
  assign w_sel_funct3 = (r_state == IDLE) ? req_funct3      : r_funct3;
  assign w_sel_lane   = (r_state == IDLE) ? req_addr[1:0]   : r_lane;

  lsu_align u_align (
    .i_we          (w_sel_we),
    .i_funct3      (w_sel_funct3),
    .i_lane        (w_sel_lane),
    .i_wdata       (req_wdata),
    .i_rdata       (mem.bus_rdata),
    .o_store_wdata (w_store_wdata),
    .o_store_wstrb (w_store_wstrb),
    .o_load_data   (w_load_data),
    .o_misaligned  (w_misaligned),
    .o_illegal     (w_illegal)
  );

  assign w_fault  = w_misaligned | w_illegal;
  assign w_launch = (r_state == IDLE) && req_valid && !w_fault;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, watchdog count and response payload
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_rdata_nxt = 32'h0;
    w_rsp_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_fault) begin
            w_state_nxt   = RESP;
            w_rsp_err_nxt = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem.bus_ready) begin
          if (r_we) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT_R;
            w_cnt_nxt   = 8'h00;
          end
        end
      end
      WAIT_R: begin
        w_cnt_nxt = r_cnt + 8'h01;
        if (mem.bus_rvalid) begin
          w_state_nxt     = RESP;
          w_rsp_rdata_nxt = w_load_data;
        end else if (r_cnt == c_timeout_m1) begin
          w_state_nxt   = RESP;
          w_rsp_err_nxt = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the access attributes and the bus request on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wstrb <= 4'h0;
      r_bus_wdata <= 32'h0;
    end else if (w_launch) begin
      r_we        <= req_we;
      r_funct3    <= req_funct3;
      r_lane      <= req_addr[1:0];
      r_bus_we    <= req_we;
      r_bus_addr  <= {req_addr[31:2], 2'b00};
      r_bus_wstrb <= w_store_wstrb;
      r_bus_wdata <= w_store_wdata;
    end
  end

  // Response-timeout watchdog counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'h00;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Response payload register; zero whenever no response is being presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready     = (r_state == IDLE);
  assign rsp_valid     = (r_state == RESP);
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign stall         = req_valid & ~rsp_valid;

  assign mem.bus_valid = (r_state == REQ);
  assign mem.bus_we    = r_bus_we;
  assign mem.bus_addr  = r_bus_addr;
  assign mem.bus_wstrb = r_bus_wstrb;
  assign mem.bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench for lsu: directed vector table, reset
//                and idle corner sequences, and random accesses compared to
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;
  localparam int T = 4;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  rdy;   // bus_valid cycles without bus_ready before the handshake
    logic [7:0]  rv;    // cycles after handshake until rvalid; 0 = never
  } stim_t;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
    logic [7:0]  bus_cycles;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  wait_lat;
    logic        stable;
    logic        stall_ok;
    logic        after_ok;
    logic        ready_ok;
  } res_t;

  typedef struct {
    stim_t s;
    res_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  lsu_if mem_if ();

  lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .stall      (stall),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int rdy, input int rv);
    stim_t s;
    s.we = we; s.f3 = f3; s.addr = addr; s.wdata = wdata; s.rdata = rdata;
    s.rdy = 8'(rdy); s.rv = 8'(rv);
    return s;
  endfunction

  function automatic res_t mk_exp(input logic err, input logic [31:0] rdata, input int lat,
                                  input int bcyc, input logic [31:0] addr, input logic we,
                                  input logic [3:0] wstrb, input logic [31:0] wdata, input int wl);
    res_t e;
    e = '0;
    e.done = 1'b1; e.stable = 1'b1; e.stall_ok = 1'b1; e.after_ok = 1'b1; e.ready_ok = 1'b1;
    e.err = err; e.rdata = rdata; e.lat = 8'(lat); e.bus_cycles = 8'(bcyc);
    e.addr = addr; e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.wait_lat = 8'(wl);
    return e;
  endfunction

  // Reference model: derived from access size arithmetic, not from FSM states
  function automatic res_t model(input stim_t s);
    res_t        e;
    int          size;
    int          lane;
    logic        legal;
    logic [31:0] v;
    e = mk_exp(1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 0);
    lane  = int'(s.addr[1:0]);
    size  = 1 << s.f3[1:0];
    legal = s.we ? (s.f3 <= 3'd2) : (s.f3 <= 3'd2 || s.f3 == 3'd4 || s.f3 == 3'd5);
    if (!legal || (s.addr % size) != 0) begin
      e.err = 1'b1;
      e.lat = 8'd1;
      return e;
    end
    e.bus_cycles = s.rdy + 8'd1;
    e.addr       = s.addr & ~32'h3;
    e.we         = s.we;
    if (s.we) begin
      e.wstrb = 4'(((1 << size) - 1) << lane);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = s.wdata[8*(i % size) +: 8];
      e.lat = 8'(int'(s.rdy) + 2);
    end else if (s.rv >= 8'd1 && int'(s.rv) <= T) begin
      v = s.rdata >> (8 * lane);
      if (size == 1) v = s.f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (size == 2) v = s.f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      e.rdata    = v;
      e.lat      = 8'(int'(s.rdy) + 2 + int'(s.rv));
      e.wait_lat = s.rv;
    end else begin
      e.err      = 1'b1;
      e.lat      = 8'(int'(s.rdy) + 2 + T);
      e.wait_lat = 8'(T);
    end
    return e;
  endfunction

  // Present one request and act as the memory until the response pulse
  task automatic run_txn(input stim_t s, output res_t o);
    int cyc;
    int vcnt;
    int hs;
    o = '0;
    o.stable = 1'b1; o.stall_ok = 1'b1;
    hs = -1; vcnt = 0; cyc = 0;
    o.ready_ok = (req_ready === 1'b1);
    req_valid = 1'b1; req_we = s.we; req_funct3 = s.f3; req_addr = s.addr; req_wdata = s.wdata;
    mem_if.bus_ready = 1'b0; mem_if.bus_rvalid = 1'b0;
    while (cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mem_if.bus_ready  = 1'b0;
      mem_if.bus_rvalid = 1'b0;
      mem_if.bus_rdata  = $urandom;
      if (rsp_valid === 1'b1) begin
        o.done = 1'b1; o.lat = 8'(cyc); o.rdata = rsp_rdata; o.err = rsp_err;
        o.wait_lat = (hs > 0) ? 8'(cyc - hs) : 8'd0;
        if (stall !== 1'b0) o.stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) o.stall_ok = 1'b0;
      if (mem_if.bus_valid === 1'b1) begin
        vcnt++;
        if (vcnt == 1) begin
          o.addr = mem_if.bus_addr; o.we = mem_if.bus_we;
          o.wstrb = mem_if.bus_wstrb; o.wdata = mem_if.bus_wdata;
        end else if (o.addr !== mem_if.bus_addr || o.we !== mem_if.bus_we ||
                     o.wstrb !== mem_if.bus_wstrb || o.wdata !== mem_if.bus_wdata) begin
          o.stable = 1'b0;
        end
        if (vcnt > int'(s.rdy)) begin
          mem_if.bus_ready = 1'b1;
          hs = cyc + 1;
        end
      end
      if (hs > 0 && s.rv != 8'd0 && (cyc + 1 - hs) == int'(s.rv)) begin
        mem_if.bus_rvalid = 1'b1;
        mem_if.bus_rdata  = s.rdata;
      end
    end
    o.bus_cycles = 8'(vcnt);
    req_valid = 1'b0;
    mem_if.bus_ready = 1'b0; mem_if.bus_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o.after_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic compare(input string tag, input stim_t s, input res_t g, input res_t e);
    chk({tag, " done"},     32'(g.done),       32'(e.done));
    chk({tag, " err"},      32'(g.err),        32'(e.err));
    chk({tag, " rdata"},    g.rdata,           e.rdata);
    chk({tag, " latency"},  32'(g.lat),        32'(e.lat));
    chk({tag, " stall"},    32'(g.stall_ok),   32'(e.stall_ok));
    chk({tag, " pulse"},    32'(g.after_ok),   32'(e.after_ok));
    chk({tag, " ready"},    32'(g.ready_ok),   32'(e.ready_ok));
    chk({tag, " buscyc"},   32'(g.bus_cycles), 32'(e.bus_cycles));
    if (e.bus_cycles != 8'd0) begin
      chk({tag, " bus_addr"}, g.addr,         e.addr);
      chk({tag, " bus_we"},   32'(g.we),      32'(e.we));
      chk({tag, " stable"},   32'(g.stable),  32'(e.stable));
      if (s.we) begin
        chk({tag, " wstrb"},  32'(g.wstrb),   32'(e.wstrb));
        chk({tag, " wdata"},  g.wdata,        e.wdata);
      end else begin
        chk({tag, " waitlat"}, 32'(g.wait_lat), 32'(e.wait_lat));
      end
    end
  endtask

  initial begin
    vec_t  tbl [16];
    res_t  got;
    stim_t s;

    // Directed vectors with hand-derived expectations (TIMEOUT_CYCLES = 4)
    tbl[0]  = '{mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0), mk_exp(0, 0, 2, 1, 32'h100, 1, 4'hF, 32'hDEADBEEF, 0)};
    tbl[1]  = '{mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0), mk_exp(0, 0, 2, 1, 32'h100, 1, 4'h8, 32'hA5A5A5A5, 0)};
    tbl[2]  = '{mk(0, 3'b000, 32'h202, 0, 32'h12C35678, 0, 1), mk_exp(0, 32'hFFFFFFC3, 3, 1, 32'h200, 0, 0, 0, 1)};
    tbl[3]  = '{mk(0, 3'b100, 32'h202, 0, 32'h12C35678, 0, 1), mk_exp(0, 32'h000000C3, 3, 1, 32'h200, 0, 0, 0, 1)};
    tbl[4]  = '{mk(0, 3'b001, 32'h202, 0, 32'h12C35678, 0, 1), mk_exp(0, 32'h000012C3, 3, 1, 32'h200, 0, 0, 0, 1)};
    tbl[5]  = '{mk(0, 3'b010, 32'h101, 0, 0, 0, 1),            mk_exp(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{mk(1, 3'b001, 32'h003, 32'h1234, 0, 0, 0),     mk_exp(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{mk(0, 3'b011, 32'h100, 0, 0, 0, 1),            mk_exp(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{mk(0, 3'b010, 32'h300, 0, 32'h55AA55AA, 3, 0), mk_exp(1, 0, 9, 4, 32'h300, 0, 0, 0, 4)};
    tbl[9]  = '{mk(0, 3'b001, 32'h402, 0, 32'h80017FFF, 0, 2), mk_exp(0, 32'hFFFF8001, 4, 1, 32'h400, 0, 0, 0, 2)};
    tbl[10] = '{mk(0, 3'b101, 32'h402, 0, 32'h80017FFF, 0, 2), mk_exp(0, 32'h00008001, 4, 1, 32'h400, 0, 0, 0, 2)};
    tbl[11] = '{mk(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1, 0), mk_exp(0, 0, 3, 2, 32'h100, 1, 4'hC, 32'hABCDABCD, 0)};
    tbl[12] = '{mk(0, 3'b010, 32'h600, 0, 32'hCAFEF00D, 0, 4), mk_exp(0, 32'hCAFEF00D, 6, 1, 32'h600, 0, 0, 0, 4)};
    tbl[13] = '{mk(1, 3'b100, 32'h000, 32'hFF, 0, 0, 0),       mk_exp(1, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{mk(0, 3'b000, 32'h001, 0, 32'h00007F00, 0, 1), mk_exp(0, 32'h0000007F, 3, 1, 32'h000, 0, 0, 0, 1)};
    tbl[15] = '{mk(0, 3'b010, 32'h700, 0, 32'h11111111, 2, 5), mk_exp(1, 0, 8, 3, 32'h700, 0, 0, 0, 4)};

    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    mem_if.bus_ready = 1'b0; mem_if.bus_rvalid = 1'b0; mem_if.bus_rdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);
    chk("reset stall",     32'(stall), 32'd0);
    chk("reset bus_valid", 32'(mem_if.bus_valid), 32'd0);
    chk("reset bus_addr",  mem_if.bus_addr, 32'h0);
    chk("reset bus_wstrb", 32'(mem_if.bus_wstrb), 32'd0);
    chk("reset bus_wdata", mem_if.bus_wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].s, got);
      compare($sformatf("vec%0d", i), tbl[i].s, got, tbl[i].e);
    end

    // Read-data-valid while idle must not produce a response
    mem_if.bus_rvalid = 1'b1; mem_if.bus_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    mem_if.bus_rvalid = 1'b0;
    chk("idle rvalid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle rvalid req_ready", 32'(req_ready), 32'd1);

    // Asynchronous reset while waiting for read data
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    chk("rst-seq bus_valid", 32'(mem_if.bus_valid), 32'd1);
    mem_if.bus_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_if.bus_ready = 1'b0;
    chk("rst-seq in wait req_ready", 32'(req_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst-seq async req_ready", 32'(req_ready), 32'd1);
    chk("rst-seq async bus_valid", 32'(mem_if.bus_valid), 32'd0);
    chk("rst-seq async rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst-seq held rsp_valid", 32'(rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst-seq post rsp_valid", 32'(rsp_valid), 32'd0);
    s = mk(0, 3'b010, 32'h504, 0, 32'h600DF00D, 0, 1);
    run_txn(s, got);
    compare("post-reset LW", s, got, model(s));

    // Random accesses against the reference model
    for (int i = 0; i < 80; i++) begin
      s = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      run_txn(s, got);
      compare($sformatf("rnd%0d", i), s, got, model(s));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
